hazard_forward: RTL and testbench

- Backward-direction companion to the pipeline register walls: returns in-flight results from EX/MEM/WB to the decode operands, and halts issue on load-use hazards.
- Keeps its own shadow pipeline (EX, MEM, WB) of destination address, write-enable and load flag, plus a WB data latch.
- Produces forwarded ra/rt operand data and the stall/bubble controls that the register walls and controller consume.

---
 rtl/hazard_forward_pkg.sv | 32 +++
 rtl/hazard_forward_if.sv | 48 ++++
 rtl/hazard_forward_operand_mux.sv | 58 +++++
 rtl/hazard_forward.sv | 78 +++++++
 tb/tb_hazard_forward.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_pkg.sv
// Shared types for the hazard/forwarding unit.
// Shadow-entry layout, forward-select encoding and the hit test.
package hazard_forward_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [ADDR_W_DEF-1:0] addr;
        logic                  is_load;
    } shadow_t;

    function automatic logic entry_hit(
        input shadow_t               e,
        input logic [ADDR_W_DEF-1:0] a,
        input logic                  used,
        input bit                    zero_hw
    );
        return e.valid & e.wr_en & used & (e.addr == a)
             & ~(zero_hw & (e.addr == '0));
    endfunction

endpackage

// File: rtl/hazard_forward_if.sv
// Decode-side bundle between the decoder/datapath and the forwarding unit.
interface hazard_forward_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              iDEC_valid;
    logic [ADDR_W-1:0] iDEC_ra_addr;
    logic [ADDR_W-1:0] iDEC_rt_addr;
    logic              iDEC_ra_used;
    logic              iDEC_rt_used;
    logic [ADDR_W-1:0] iDEC_write_reg_addr;
    logic              iDEC_do_reg_write;
    logic              iDEC_do_dm_read;
    logic [DATA_W-1:0] iRF_ra_data;
    logic [DATA_W-1:0] iRF_rt_data;
    logic [DATA_W-1:0] iEX_alu_result;
    logic [DATA_W-1:0] iMEM_write_reg_data;
    logic [DATA_W-1:0] oFWD_ra_data;
    logic [DATA_W-1:0] oFWD_rt_data;
    logic [1:0]        oFWD_ra_sel;
    logic [1:0]        oFWD_rt_sel;
    logic              oSTALL;
    logic              oBUBBLE;

    modport master (
        output iDEC_valid, iDEC_ra_addr, iDEC_rt_addr,
        output iDEC_ra_used, iDEC_rt_used,
        output iDEC_write_reg_addr, iDEC_do_reg_write,
        output iDEC_do_dm_read,
        output iRF_ra_data, iRF_rt_data,
        output iEX_alu_result, iMEM_write_reg_data,
        input  oFWD_ra_data, oFWD_rt_data,
        input  oFWD_ra_sel, oFWD_rt_sel,
        input  oSTALL, oBUBBLE
    );

    modport slave (
        input  iDEC_valid, iDEC_ra_addr, iDEC_rt_addr,
        input  iDEC_ra_used, iDEC_rt_used,
        input  iDEC_write_reg_addr, iDEC_do_reg_write,
        input  iDEC_do_dm_read,
        input  iRF_ra_data, iRF_rt_data,
        input  iEX_alu_result, iMEM_write_reg_data,
        output oFWD_ra_data, oFWD_rt_data,
        output oFWD_ra_sel, oFWD_rt_sel,
        output oSTALL, oBUBBLE
    );
endinterface

// File: rtl/hazard_forward_operand_mux.sv
// Per-operand forward selection: youngest writer wins, EX loads flag a hazard.
module forward_operand_mux
    import hazard_forward_pkg::*;
#(
    parameter int DATA_W             = DATA_W_DEF,
    parameter int ADDR_W             = ADDR_W_DEF,
    parameter bit ZERO_REG_HARDWIRED = 1'b0
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              used_i,
    input  shadow_t           ex_i,
    input  shadow_t           mem_i,
    input  shadow_t           wb_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic [DATA_W-1:0] ex_data_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output fwd_sel_e          sel_o,
    output logic [DATA_W-1:0] data_o,
    output logic              load_hit_o
);
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic unused_load_flags;

    assign ex_hit  = entry_hit(ex_i, addr_i, used_i, ZERO_REG_HARDWIRED);
    assign mem_hit = entry_hit(mem_i, addr_i, used_i, ZERO_REG_HARDWIRED);
    assign wb_hit  = entry_hit(wb_i, addr_i, used_i, ZERO_REG_HARDWIRED);
    assign unused_load_flags = mem_i.is_load ^ wb_i.is_load;

    // An EX load owns the operand: no fallback to older stages while it stalls.
    always_comb begin
        sel_o      = FWD_RF;
        load_hit_o = 1'b0;
        if (ex_hit) begin
            if (ex_i.is_load) begin
                load_hit_o = 1'b1;
            end else begin
                sel_o = FWD_EX;
            end
        end else if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

    always_comb begin
        data_o = rf_data_i;
        unique case (sel_o)
            FWD_RF:  data_o = rf_data_i;
            FWD_EX:  data_o = ex_data_i;
            FWD_MEM: data_o = mem_data_i;
            FWD_WB:  data_o = wb_data_i;
        endcase
    end
endmodule

// File: rtl/hazard_forward.sv
// Shadow EX/MEM/WB pipeline feeding operand forwarding and load-use stall.
module hazard_forward
    import hazard_forward_pkg::*;
#(
    parameter int DATA_W             = DATA_W_DEF,
    parameter int ADDR_W             = ADDR_W_DEF,
    parameter bit ZERO_REG_HARDWIRED = 1'b0
) (
    input  logic           clock,
    input  logic           reset,
    hazard_forward_if.slave bus
);
    shadow_t           ex_q, ex_d;
    shadow_t           mem_q, mem_d;
    shadow_t           wb_q, wb_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    fwd_sel_e          ra_sel, rt_sel;
    logic              ra_load_hit, rt_load_hit;
    logic              stall;

    assign stall = bus.iDEC_valid & (ra_load_hit | rt_load_hit);

    // A stalled decode leaves a bubble behind it in EX.
    always_comb begin
        ex_d         = '0;
        ex_d.valid   = bus.iDEC_valid & ~stall;
        ex_d.wr_en   = bus.iDEC_do_reg_write;
        ex_d.addr    = bus.iDEC_write_reg_addr;
        ex_d.is_load = bus.iDEC_do_dm_read;
    end

    assign mem_d     = ex_q;
    assign wb_d      = mem_q;
    assign wb_data_d = bus.iMEM_write_reg_data;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            wb_data_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            wb_data_q <= wb_data_d;
        end
    end

    forward_operand_mux #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
    ) u_ra (
        .addr_i(bus.iDEC_ra_addr), .used_i(bus.iDEC_ra_used),
        .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
        .rf_data_i(bus.iRF_ra_data), .ex_data_i(bus.iEX_alu_result),
        .mem_data_i(bus.iMEM_write_reg_data), .wb_data_i(wb_data_q),
        .sel_o(ra_sel), .data_o(bus.oFWD_ra_data),
        .load_hit_o(ra_load_hit)
    );

    forward_operand_mux #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
    ) u_rt (
        .addr_i(bus.iDEC_rt_addr), .used_i(bus.iDEC_rt_used),
        .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
        .rf_data_i(bus.iRF_rt_data), .ex_data_i(bus.iEX_alu_result),
        .mem_data_i(bus.iMEM_write_reg_data), .wb_data_i(wb_data_q),
        .sel_o(rt_sel), .data_o(bus.oFWD_rt_data),
        .load_hit_o(rt_load_hit)
    );

    assign bus.oFWD_ra_sel = ra_sel;
    assign bus.oFWD_rt_sel = rt_sel;
    assign bus.oSTALL      = stall;
    assign bus.oBUBBLE     = stall;
endmodule

// File: tb/tb_hazard_forward.sv
// Scoreboard bench for hazard_forward: two instances, zero-reg off and on.
module tb_hazard_forward;

    typedef struct packed {
        logic [1:0]  ras;
        logic [31:0] rad;
        logic [1:0]  rts;
        logic [31:0] rtd;
        logic        st;
        logic        bb;
    } exp_t;

    typedef struct {
        logic        v;
        logic [4:0]  ra, rt;
        logic        rau, rtu;
        logic [4:0]  wa;
        logic        we, ld;
        logic [31:0] rfa, rfb, exr, memr;
        exp_t        e;
    } stim_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    hazard_forward_if if0 ();
    hazard_forward_if if1 ();

    assign if1.iDEC_valid          = if0.iDEC_valid;
    assign if1.iDEC_ra_addr        = if0.iDEC_ra_addr;
    assign if1.iDEC_rt_addr        = if0.iDEC_rt_addr;
    assign if1.iDEC_ra_used        = if0.iDEC_ra_used;
    assign if1.iDEC_rt_used        = if0.iDEC_rt_used;
    assign if1.iDEC_write_reg_addr = if0.iDEC_write_reg_addr;
    assign if1.iDEC_do_reg_write   = if0.iDEC_do_reg_write;
    assign if1.iDEC_do_dm_read     = if0.iDEC_do_dm_read;
    assign if1.iRF_ra_data         = if0.iRF_ra_data;
    assign if1.iRF_rt_data         = if0.iRF_rt_data;
    assign if1.iEX_alu_result      = if0.iEX_alu_result;
    assign if1.iMEM_write_reg_data = if0.iMEM_write_reg_data;

    hazard_forward #(.ZERO_REG_HARDWIRED(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .bus(if0)
    );

    hazard_forward #(.ZERO_REG_HARDWIRED(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .bus(if1)
    );

    function automatic exp_t E(input logic [1:0] sa, input logic [31:0] da,
                               input logic [1:0] sb_, input logic [31:0] db,
                               input logic st);
        return {sa, da, sb_, db, st, st};
    endfunction

    function automatic stim_t S(input logic v, input logic [4:0] ra, rt,
                                input logic rau, rtu, input logic [4:0] wa,
                                input logic we, ld,
                                input logic [31:0] rfa, rfb, exr, memr,
                                input exp_t e);
        stim_t s;
        s.v = v; s.ra = ra; s.rt = rt; s.rau = rau; s.rtu = rtu;
        s.wa = wa; s.we = we; s.ld = ld;
        s.rfa = rfa; s.rfb = rfb; s.exr = exr; s.memr = memr; s.e = e;
        return s;
    endfunction

    function automatic exp_t obs0();
        return {if0.oFWD_ra_sel, if0.oFWD_ra_data, if0.oFWD_rt_sel,
                if0.oFWD_rt_data, if0.oSTALL, if0.oBUBBLE};
    endfunction

    function automatic exp_t obs1();
        return {if1.oFWD_ra_sel, if1.oFWD_ra_data, if1.oFWD_rt_sel,
                if1.oFWD_rt_data, if1.oSTALL, if1.oBUBBLE};
    endfunction

    task automatic drive(input stim_t s);
        @(posedge clock);
        #1;
        if0.iDEC_valid          = s.v;
        if0.iDEC_ra_addr        = s.ra;
        if0.iDEC_rt_addr        = s.rt;
        if0.iDEC_ra_used        = s.rau;
        if0.iDEC_rt_used        = s.rtu;
        if0.iDEC_write_reg_addr = s.wa;
        if0.iDEC_do_reg_write   = s.we;
        if0.iDEC_do_dm_read     = s.ld;
        if0.iRF_ra_data         = s.rfa;
        if0.iRF_rt_data         = s.rfb;
        if0.iEX_alu_result      = s.exr;
        if0.iMEM_write_reg_data = s.memr;
        sb.push_back(s.e);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) begin
            drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0)));
            void'(sb.pop_front());
        end
    endtask

    task automatic test_reset();
        exp_t got, e;
        for (int i = 0; i < 2; i++) begin
            drive(S(1, 3, 4, 1, 1, 3, 1, 1, 'hAA, 'hBB, 'h5, 'h6,
                    E(0, 'hAA, 0, 'hBB, 0)));
            #1;
            got = obs0(); e = sb.pop_front(); total++;
            if (got !== e) $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
            else passed++;
        end
        @(posedge clock);
        reset = 1'b0;
    endtask

    task automatic test_alu_b2b();
        stim_t t[3];
        exp_t  got, e;
        flush();
        t[0] = S(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0));
        t[1] = S(1, 3, 0, 1, 0, 9, 0, 0, 'h77, 'h66, 'h5, 'h99,
                 E(1, 'h5, 0, 'h66, 0));
        t[2] = S(1, 3, 3, 1, 1, 9, 0, 0, 'h1, 'h2, 'h55, 'h33,
                 E(2, 'h33, 2, 'h33, 0));
        foreach (t[i]) begin
            drive(t[i]);
            #1;
            got = obs0(); e = sb.pop_front(); total++;
            if (got !== e) $display("FAIL alu_b2b[%0d] got=%h exp=%h", i, got, e);
            else passed++;
        end
    endtask

    task automatic test_load_use();
        stim_t t[3];
        exp_t  got, e;
        flush();
        t[0] = S(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, E(0, 0, 0, 0, 0));
        t[1] = S(1, 1, 4, 1, 1, 2, 1, 0, 'h10, 'h20, 'hBAD, 'h0,
                 E(0, 'h10, 0, 'h20, 1));
        t[2] = S(1, 1, 4, 1, 1, 2, 1, 0, 'h10, 'h20, 'hBAD, 'hDEADBEEF,
                 E(0, 'h10, 2, 'hDEADBEEF, 0));
        foreach (t[i]) begin
            drive(t[i]);
            #1;
            got = obs0(); e = sb.pop_front(); total++;
            if (got !== e) $display("FAIL load_use[%0d] got=%h exp=%h", i, got, e);
            else passed++;
        end
    endtask

    task automatic test_load_block();
        stim_t t[4];
        exp_t  got, e;
        flush();
        t[0] = S(1, 0, 0, 0, 0, 6, 1, 0, 'h1, 'h2, 'h60, 'h0, E(0, 'h1, 0, 'h2, 0));
        t[1] = S(1, 0, 0, 0, 0, 6, 1, 1, 'h1, 'h2, 'h61, 'h0, E(0, 'h1, 0, 'h2, 0));
        t[2] = S(1, 6, 0, 1, 0, 10, 1, 0, 'h3, 'h4, 'h62, 'h60,
                 E(0, 'h3, 0, 'h4, 1));
        t[3] = S(1, 6, 0, 1, 0, 10, 1, 0, 'h3, 'h4, 'h63, 'hCAFE,
                 E(2, 'hCAFE, 0, 'h4, 0));
        foreach (t[i]) begin
            drive(t[i]);
            #1;
            got = obs0(); e = sb.pop_front(); total++;
            if (got !== e) $display("FAIL load_block[%0d] got=%h exp=%h", i, got, e);
            else passed++;
        end
    endtask

    task automatic test_distance3();
        stim_t t[5];
        exp_t  got, e;
        flush();
        t[0] = S(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 'h1234, 0, E(0, 0, 0, 0, 0));
        t[1] = S(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 'h8, 0, E(0, 0, 0, 0, 0));
        t[2] = S(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 'h9, 'h1234, E(0, 0, 0, 0, 0));
        t[3] = S(1, 7, 0, 1, 0, 0, 0, 0, 'h0, 'hB, 'hEEEE, 'hFFFF,
                 E(3, 'h1234, 0, 'hB, 0));
        t[4] = S(1, 0, 7, 0, 1, 0, 0, 0, 'hA, 'hC, 'hEEEE, 'hFFFF,
                 E(0, 'hA, 0, 'hC, 0));
        foreach (t[i]) begin
            drive(t[i]);
            #1;
            got = obs0(); e = sb.pop_front(); total++;
            if (got !== e) $display("FAIL distance3[%0d] got=%h exp=%h", i, got, e);
            else passed++;
        end
    endtask

    task automatic test_waw();
        stim_t t[5];
        exp_t  got, e;
        flush();
        t[0] = S(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 'h11, 0, E(0, 0, 0, 0, 0));
        t[1] = S(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 'h22, 'h11, E(0, 0, 0, 0, 0));
        t[2] = S(1, 5, 5, 1, 1, 0, 0, 0, 'h1, 'h2, 'h22, 'h11,
                 E(1, 'h22, 1, 'h22, 0));
        t[3] = S(1, 5, 5, 1, 1, 0, 0, 0, 'h1, 'h2, 'h77, 'h22,
                 E(2, 'h22, 2, 'h22, 0));
        t[4] = S(1, 5, 5, 1, 1, 0, 0, 0, 'h1, 'h2, 'h98, 'h99,
                 E(3, 'h22, 3, 'h22, 0));
        foreach (t[i]) begin
            drive(t[i]);
            #1;
            got = obs0(); e = sb.pop_front(); total++;
            if (got !== e) $display("FAIL waw[%0d] got=%h exp=%h", i, got, e);
            else passed++;
        end
    endtask

    task automatic test_zero_reg();
        exp_t got, e;
        flush();
        drive(S(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, E(0, 0, 0, 0, 0)));
        void'(sb.pop_front());
        drive(S(1, 0, 0, 1, 0, 3, 1, 0, 'h5A, 'h6B, 'h1, 'h2,
                E(0, 'h5A, 0, 'h6B, 0)));
        #1;
        got = obs1(); e = sb.pop_front(); total++;
        if (got !== e) $display("FAIL zero_reg_hw got=%h exp=%h", got, e);
        else passed++;
        total++;
        if (if0.oSTALL !== 1'b1 || if0.oBUBBLE !== 1'b1)
            $display("FAIL zero_reg_soft stall=%b bubble=%b exp=1",
                     if0.oSTALL, if0.oBUBBLE);
        else passed++;
    endtask

    task automatic test_invalid();
        flush();
        drive(S(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, E(0, 0, 0, 0, 0)));
        void'(sb.pop_front());
        drive(S(0, 0, 4, 0, 1, 0, 0, 0, 0, 'h4, 0, 0, E(0, 0, 0, 0, 0)));
        void'(sb.pop_front());
        #1;
        total++;
        if (if0.oSTALL !== 1'b0 || if0.oBUBBLE !== 1'b0)
            $display("FAIL invalid_no_stall stall=%b bubble=%b exp=0",
                     if0.oSTALL, if0.oBUBBLE);
        else passed++;
    endtask

    task automatic test_reset_midstall();
        exp_t got, e;
        flush();
        drive(S(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, E(0, 0, 0, 0, 0)));
        void'(sb.pop_front());
        drive(S(1, 0, 4, 0, 1, 0, 0, 0, 'h1, 'h44, 0, 0, E(0, 'h1, 0, 'h44, 1)));
        #1;
        got = obs0(); e = sb.pop_front(); total++;
        if (got !== e) $display("FAIL midstall_pre got=%h exp=%h", got, e);
        else passed++;
        reset = 1'b1;
        sb.push_back(E(0, 'h1, 0, 'h44, 0));
        #1;
        got = obs0(); e = sb.pop_front(); total++;
        if (got !== e) $display("FAIL midstall_async got=%h exp=%h", got, e);
        else passed++;
        @(posedge clock);
        reset = 1'b0;
        drive(S(1, 0, 4, 0, 1, 0, 0, 0, 'h1, 'h45, 'h7, 'h8, E(0, 'h1, 0, 'h45, 0)));
        #1;
        got = obs0(); e = sb.pop_front(); total++;
        if (got !== e) $display("FAIL midstall_post got=%h exp=%h", got, e);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alu_b2b();
        test_load_use();
        test_load_block();
        test_distance3();
        test_waw();
        test_zero_reg();
        test_invalid();
        test_reset_midstall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
